spi_xfer_sequencer: RTL
=======================

// Module: spi_xfer_sequencer
// PURPOSE
// - Bus master sitting directly upstream of the SPI ctrl-bus peripheral (addr 0x04 CS, 0x08 data).
// - Turns one command (CS pattern + byte count) plus a TX byte stream into a CS-framed SPI burst.
// - Returns each received byte on an RX stream, so a full transfer runs without CPU per-byte polling.
// PARAMETERS
// - CS_LENGTH       32    width of chip-select pattern; matches the peripheral's CS register
// - LEN_WIDTH       16    width of byte count
// - TIMEOUT_CYCLES  4096  max cycles from issuing a ctrl request to ctrl_done (SPI_SEQ_TIMEOUT_EN only)
// PORTS
// - clk        in   1          clock
// - resetn     in   1          reset, synchronous, active-low
// - cmd_valid  in   1          command request
// - cmd_ready  out  1          high only in IDLE; command accepted when cmd_valid & cmd_ready
// - cmd_cs     in   CS_LENGTH  CS register value for the burst (active-low pattern, written as-is)
// - cmd_len    in   LEN_WIDTH  number of bytes; 0 = CS pulse only
// - cmd_rx_en  in   1          1 = read back and emit RX bytes; 0 = discard them
// - tx_valid / tx_ready / tx_data[7:0]   in/out/in   TX byte stream (valid/ready)
// - rx_valid / rx_ready / rx_data[7:0]   out/in/out  RX byte stream (valid/ready)
// - busy       out  1          high from command accept until return to IDLE
// - done       out  1          one-cycle pulse on burst completion (normal or error)
// - err        out  1          sticky timeout flag; cleared on next command accept
// - ctrl_wr, ctrl_rd  out 1    peripheral request strobes
// - ctrl_addr  out  8          peripheral register address
// - ctrl_wdat  out  32         write data
// - ctrl_rdat  in   32         read data; valid only in the cycle ctrl_done=1
// - ctrl_done  in   1          peripheral completion, one-cycle pulse
// BEHAVIOUR
// - Reset: every output 0, except that cmd_ready goes to 1 in the first cycle after reset (state IDLE).
//   - An asserted resetn mid-burst abandons the burst immediately; no CS-off write is issued.
// - Ctrl handshake:
//   - Assert ctrl_wr or ctrl_rd (never both) with addr/wdat stable.
//   - Hold the request until ctrl_done is sampled high.
//   - Deassert the request in the following cycle.
//   - Leave at least one idle cycle before the next request, because the peripheral ignores requests in its done cycle.
//   - Capture ctrl_rdat[7:0] in the ctrl_done cycle.
// - FSM states: IDLE, CS_ON, WAIT_TX, XFER, READ, PUSH, CS_OFF.
//   - IDLE: on accept, latch cs/len/rx_en, set busy, clear err, cnt <= cmd_len -> CS_ON.
//   - CS_ON: WR 0x04 wdat={{32-CS_LENGTH}{1'b1}},cmd_cs}; on done -> (cnt==0 ? CS_OFF : WAIT_TX).
//   - WAIT_TX: tx_ready=1; on tx_valid, latch tx_data -> XFER. tx_ready is high only in this state.
//   - XFER: WR 0x08 wdat={24'b0,byte}; on done -> (rx_en ? READ : next).
//   - READ: RD 0x08; on done, rx_data <= ctrl_rdat[7:0] -> PUSH.
//   - PUSH: rx_valid=1 until rx_ready; rx_data is held stable while stalled -> next.
//   - next: cnt <= cnt-1; -> (cnt==1 ? CS_OFF : WAIT_TX).
//   - CS_OFF: WR 0x04 wdat=32'hFFFFFFFF; on done: pulse done, clear busy -> IDLE.
// - Counting: cnt is LEN_WIDTH bits and decrements only; max burst 2^LEN_WIDTH-1 bytes; no wrap.
// - Byte timing: one byte costs 2 ctrl transactions plus idle gaps; SPI clock rate is set solely by the peripheral prescaler.
// - Sequencer never writes 0x00 or 0x0C; mode and prescale belong to software.
// - cmd_valid while busy is ignored (cmd_ready=0); tx/rx streams never stall each other outside WAIT_TX/PUSH.
// CONFIGURATION
// - SPI_SEQ_TIMEOUT_EN defined:
//   - A counter runs while ctrl_wr|ctrl_rd is asserted.
//   - If it reaches TIMEOUT_CYCLES without ctrl_done: drop the request, set err, go to CS_OFF (one retry of the CS-off write).
//   - If CS_OFF also times out: go to IDLE with done pulse.
// - SPI_SEQ_TIMEOUT_EN undefined: no counter; the sequencer waits forever for ctrl_done; err is tied 0.
// TESTING
// - cmd_cs=~1, len=2, rx_en=1, tx 0xA5,0x3C, loopback model -> ctrl sequence WR04(FFFFFFFE), WR08(A5), RD08, WR08(3C), RD08, WR04(FFFFFFFF); rx 0xA5,0x3C; one done pulse.
// - len=0 -> only WR04(cs), WR04(FFFFFFFF); no tx_ready, no rx_valid; done after the 2nd ctrl_done.
// - rx_en=0, len=3 -> three WR08, zero RD08, rx_valid never high.
// - rx_ready held low 20 cycles in PUSH -> rx_data stable, no further ctrl request, tx_ready=0, resume after ready.
// - resetn low during XFER -> next cycle all ctrl strobes 0, busy 0, cmd_ready 1.
// - (SPI_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16) ctrl_done withheld on WR08 -> request dropped at cycle 16, err=1, WR04(FFFFFFFF) issued, done pulse.

Source files
------------

// File: rtl/spi_xfer_sequencer.sv
// SPI transfer sequencer: runs one CS-framed burst through the SPI ctrl-bus peripheral.
// Optional ctrl-request watchdog is enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_xfer_sequencer #(
  parameter int CS_LENGTH      = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CS_LENGTH-1:0] cmd_cs,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 cmd_rx_en,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [7:0]           tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [7:0]           rx_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 ctrl_wr,
  output logic                 ctrl_rd,
  output logic [7:0]           ctrl_addr,
  output logic [31:0]          ctrl_wdat,
  input  logic [31:0]          ctrl_rdat,
  input  logic                 ctrl_done
);
  localparam logic [7:0] ADDR_CS   = 8'h04;
  localparam logic [7:0] ADDR_DATA = 8'h08;

  typedef enum logic [2:0] {IDLE, CS_ON, WAIT_TX, XFER, READ, PUSH, CS_OFF} state_t;

  state_t               state;
  logic [CS_LENGTH-1:0] cs_q;
  logic [LEN_WIDTH-1:0] cnt;
  logic [7:0]           byte_q;
  logic                 rx_en_q;
  logic                 req;
  logic                 last;

  assign req  = ctrl_wr | ctrl_rd;
  assign last = (cnt == LEN_WIDTH'(1));

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo;
  logic             err_q;
  logic             expired;
  assign expired = req && !ctrl_done && (tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  // Only the low byte of a data read carries the received SPI byte.
  logic unused_rdat;
  assign unused_rdat = &{1'b0, ctrl_rdat[31:8]};

  // A request is raised only when no strobe is active, so every state entered
  // on ctrl_done spends its first cycle idle before issuing its own request.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      tx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
      ctrl_wr   <= 1'b0;
      ctrl_rd   <= 1'b0;
      ctrl_addr <= 8'h00;
      ctrl_wdat <= 32'h0;
      cnt       <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
      err_q     <= 1'b0;
      tmo       <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          cs_q      <= cmd_cs;
          rx_en_q   <= cmd_rx_en;
          cnt       <= cmd_len;
`ifdef SPI_SEQ_TIMEOUT_EN
          err_q     <= 1'b0;
`endif
          state     <= CS_ON;
        end
        CS_ON: if (!req) begin
          ctrl_wr   <= 1'b1;
          ctrl_addr <= ADDR_CS;
          ctrl_wdat <= ~(32'(~cs_q));
        end else if (ctrl_done) begin
          ctrl_wr <= 1'b0;
          if (cnt == '0) state <= CS_OFF;
          else begin
            state    <= WAIT_TX;
            tx_ready <= 1'b1;
          end
        end
        WAIT_TX: if (tx_valid) begin
          tx_ready <= 1'b0;
          byte_q   <= tx_data;
          state    <= XFER;
        end
        XFER: if (!req) begin
          ctrl_wr   <= 1'b1;
          ctrl_addr <= ADDR_DATA;
          ctrl_wdat <= {24'h0, byte_q};
        end else if (ctrl_done) begin
          ctrl_wr <= 1'b0;
          if (rx_en_q) state <= READ;
          else begin
            cnt <= cnt - 1'b1;
            if (last) state <= CS_OFF;
            else begin
              state    <= WAIT_TX;
              tx_ready <= 1'b1;
            end
          end
        end
        READ: if (!req) begin
          ctrl_rd   <= 1'b1;
          ctrl_addr <= ADDR_DATA;
          ctrl_wdat <= 32'h0;
        end else if (ctrl_done) begin
          ctrl_rd  <= 1'b0;
          rx_data  <= ctrl_rdat[7:0];
          rx_valid <= 1'b1;
          state    <= PUSH;
        end
        PUSH: if (rx_ready) begin
          rx_valid <= 1'b0;
          cnt      <= cnt - 1'b1;
          if (last) state <= CS_OFF;
          else begin
            state    <= WAIT_TX;
            tx_ready <= 1'b1;
          end
        end
        CS_OFF: if (!req) begin
          ctrl_wr   <= 1'b1;
          ctrl_addr <= ADDR_CS;
          ctrl_wdat <= 32'hFFFF_FFFF;
        end else if (ctrl_done) begin
          ctrl_wr   <= 1'b0;
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef SPI_SEQ_TIMEOUT_EN
      // Watchdog overrides the state action: drop the request, then try to release CS once.
      tmo <= (req && !ctrl_done) ? tmo + 1'b1 : '0;
      if (expired) begin
        ctrl_wr <= 1'b0;
        ctrl_rd <= 1'b0;
        err_q   <= 1'b1;
        if (state == CS_OFF) begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          done      <= 1'b1;
        end else begin
          state <= CS_OFF;
        end
      end
`endif
    end
  end
endmodule
